filt_seq_ctrl: RTL and testbench
================================

Name: filt_seq_ctrl

Overview:
- Sample-queue and sequencing controller for the FIR equalizer filters.
- Stores the last DEPTH stereo samples in a circular buffer.
- On each new sample strobe, once the buffer is primed, raises sequencing and streams all DEPTH stored samples, oldest first, one per clk.
- Sits between the codec sample interface and the HP/LP/BP filter banks. Its outputs drive their sequencing, lft_in and rght_in inputs directly.

Parameters:
- DEPTH, 1021, number of stored samples per channel = filter tap count; legal range 2..1023.
- AW, 10, pointer/counter width; must satisfy 2**AW > DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid  input  1  one-cycle strobe: new sample on lft_smpl/rght_smpl.
- lft_smpl  input  16  left sample, signed.
- rght_smpl  input  16  right sample, signed.
- sequencing  output  1  high for exactly DEPTH consecutive cycles per frame.
- lft_q  output  16  streamed left sample; meaningful only while sequencing=1.
- rght_q  output  16  streamed right sample; meaningful only while sequencing=1.
- frame_done  output  1  one-cycle pulse in the cycle after sequencing falls.
- ovr  output  1  sticky: a valid arrived while busy.

Behaviour:
- Reset (async, rst_n=0):
  - state=FILL; wr_ptr=0; fill_cnt=0.
  - sequencing=0, frame_done=0, ovr=0, lft_q=rght_q=0.
  - Buffer contents are not reset.
- Buffer:
  - DEPTH x 32 bits, 1 write port, 1 synchronous read port (1-cycle read latency).
  - A write at wr_ptr happens in the valid cycle, only when the valid is accepted.
  - wr_ptr wraps from DEPTH-1 to 0.
- fill_cnt:
  - Increments on each accepted valid and saturates at DEPTH.
  - Never decrements except on reset.
- FSM states: FILL, IDLE, PRE, SEQ, DONE.
- FILL:
  - Each valid is written.
  - If the post-write fill_cnt == DEPTH, go to PRE; otherwise stay.
- IDLE: a valid is written, then go to PRE.
- PRE (1 cycle):
  - rd_ptr = oldest entry, i.e. the wr_ptr value after the triggering write.
  - Issue a read at rd_ptr, then go to SEQ.
- SEQ:
  - sequencing=1. In the k-th SEQ cycle (k=0..DEPTH-1), lft_q/rght_q hold sample k. k=0 is the oldest; k=DEPTH-1 is the sample just written.
  - rd_ptr increments each cycle, wrapping DEPTH-1 to 0.
  - After DEPTH cycles go to DONE.
- DONE (1 cycle): frame_done=1, sequencing=0, then go to IDLE.
- Latency: a valid at cycle t gives the first sequencing cycle at t+2 and frame_done at t+2+DEPTH.
- Back-to-back frames: a valid in the DONE cycle is accepted as if in IDLE, and PRE follows immediately. sequencing therefore stays low for at least 2 cycles between frames.
- Overrun: a valid in PRE or SEQ is dropped (no write, pointers unchanged) and sets ovr=1. ovr clears only on reset.
- Output registers: sequencing, frame_done, lft_q and rght_q are registered. lft_q/rght_q hold their last value outside SEQ.
- Channel packing: left in [31:16], right in [15:0]; no arithmetic on sample data.
- Reset mid-frame: sequencing drops asynchronously. After release the block behaves as from power-up and must re-fill.

Optional Feature:
- Macro: FILT_ZERO_FILL_EN.
- Defined:
  - The buffer is treated as zero-initialized at reset.
  - FILL is skipped: the first valid after reset goes directly to PRE.
  - During SEQ, any entry k < DEPTH-fill_cnt (never written since reset) outputs lft_q=rght_q=0 instead of buffer data.
  - Frame ordering is unchanged; the newest sample is always last.
- Undefined: the behaviour is as above, with no sequencing until DEPTH samples have been accepted.

Test Plan:
- DEPTH=8; reset, then 7 valids with lft=1..7 and rght=-1..-7 -> sequencing never rises and frame_done stays 0.
- DEPTH=8; 8th valid (lft=8) at cycle t -> sequencing high for cycles t+2..t+9; lft_q=1,2,...,8 and rght_q=-1,...,-8; frame_done pulses at t+10.
- DEPTH=8; 3 more valids (9, 10, 11), each after frame_done -> each frame streams 2..9, 3..10, 4..11, confirming pointer wrap past index 7.
- DEPTH=8, primed; valid during the 4th SEQ cycle -> frame output unaffected, ovr=1; the next frame shows that sample absent.
- DEPTH=1021; 1021 ramp samples 0..1020 -> exactly 1021 sequencing cycles with lft_q=0..1020, then frame_done; rst_n low mid-SEQ -> sequencing=0 immediately, and a re-fill is required.
- FILT_ZERO_FILL_EN, DEPTH=8; first valid lft=5 -> a frame starts at t+2 and streams 0,0,0,0,0,0,0,5.

Source files
------------

// File: rtl/filt_seq_ctrl.sv
// Sample queue and frame sequencer for the FIR equalizer banks.
// Optional macro FILT_ZERO_FILL_EN: zero-initialized history, no initial fill phase.
module filt_seq_ctrl #(
  parameter int unsigned DEPTH = 1021,
  parameter int unsigned AW    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [15:0] lft_smpl,
  input  logic [15:0] rght_smpl,
  output logic        sequencing,
  output logic [15:0] lft_q,
  output logic [15:0] rght_q,
  output logic        frame_done,
  output logic        ovr
);

  typedef enum logic [2:0] {StFill, StIdle, StPre, StSeq, StDone} state_e;

  localparam logic [AW-1:0] Last = AW'(DEPTH - 1);
  localparam logic [AW-1:0] Full = AW'(DEPTH);
`ifdef FILT_ZERO_FILL_EN
  localparam state_e StReset = StIdle;
`else
  localparam state_e StReset = StFill;
`endif

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] fill_cnt_q, fill_cnt_d, cnt_q, cnt_d;
  logic          seq_q, seq_d, done_q, done_d, ovr_q, ovr_d;
  logic          accept, wr_en, rd_en, rd_zero;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_idx;
  logic [31:0]   mem [DEPTH];

  function automatic logic [AW-1:0] inc_wrap(input logic [AW-1:0] p);
    return (p == Last) ? '0 : p + AW'(1);
  endfunction

  assign accept = valid && (state_q == StFill || state_q == StIdle || state_q == StDone);

  // Frame position of the entry being loaded into the output registers.
  assign rd_idx = (state_q == StPre) ? '0 : {1'b0, cnt_q} + (AW+1)'(1);
`ifdef FILT_ZERO_FILL_EN
  assign rd_zero = (rd_idx + {1'b0, fill_cnt_q}) < (AW+1)'(DEPTH);
`else
  assign rd_zero = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_cnt_d = fill_cnt_q;
    cnt_d      = cnt_q;
    seq_d      = 1'b0;
    done_d     = 1'b0;
    ovr_d      = ovr_q;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = rd_ptr_q;

    if (accept) begin
      wr_en    = 1'b1;
      wr_ptr_d = inc_wrap(wr_ptr_q);
      if (fill_cnt_q != Full) fill_cnt_d = fill_cnt_q + AW'(1);
    end else if (valid) begin
      ovr_d = 1'b1;
    end

    unique case (state_q)
      StFill: if (accept && fill_cnt_d == Full) state_d = StPre;
      StIdle: if (accept) state_d = StPre;
      StDone: state_d = accept ? StPre : StIdle;
      StPre: begin
        // Oldest entry sits at the slot the next write would use.
        rd_en    = 1'b1;
        rd_addr  = wr_ptr_q;
        rd_ptr_d = inc_wrap(wr_ptr_q);
        cnt_d    = '0;
        seq_d    = 1'b1;
        state_d  = StSeq;
      end
      StSeq: begin
        if (cnt_q == Last) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          rd_en    = 1'b1;
          rd_ptr_d = inc_wrap(rd_ptr_q);
          cnt_d    = cnt_q + AW'(1);
          seq_d    = 1'b1;
        end
      end
      default: state_d = StReset;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= {lft_smpl, rght_smpl};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StReset;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_cnt_q <= '0;
      cnt_q      <= '0;
      seq_q      <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      lft_q      <= '0;
      rght_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      cnt_q      <= cnt_d;
      seq_q      <= seq_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      if (rd_en) begin
        {lft_q, rght_q} <= rd_zero ? 32'h0 : mem[rd_addr];
      end
    end
  end

  assign sequencing = seq_q;
  assign frame_done = done_q;
  assign ovr        = ovr_q;

endmodule

// File: tb/tb_filt_seq_ctrl.sv
// Randomized bench for filt_seq_ctrl (DEPTH=8 and DEPTH=1021) against a frame-level model.
module tb_filt_seq_ctrl;

`ifdef FILT_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v8 = 1'b0, v1k = 1'b0;
  logic [15:0] lft = '0, rght = '0;
  logic        seq8, fd8, ovr8, seq1k, fd1k, ovr1k;
  logic [15:0] lq8, rq8, lq1k, rq1k;

  always #5 clk = ~clk;

  filt_seq_ctrl #(.DEPTH(8), .AW(4)) u_d8 (
    .clk(clk), .rst_n(rst_n), .valid(v8), .lft_smpl(lft), .rght_smpl(rght),
    .sequencing(seq8), .lft_q(lq8), .rght_q(rq8), .frame_done(fd8), .ovr(ovr8)
  );

  filt_seq_ctrl #(.DEPTH(1021), .AW(10)) u_d1k (
    .clk(clk), .rst_n(rst_n), .valid(v1k), .lft_smpl(lft), .rght_smpl(rght),
    .sequencing(seq1k), .lft_q(lq1k), .rght_q(rq1k), .frame_done(fd1k), .ovr(ovr1k)
  );

  int          n_tests = 0, n_fail = 0;
  bit          big = 1'b0;
  int          dep = 8;
  int          cyc = 0;
  int          trig = -1;
  bit          ovr_e = 1'b0;
  logic [31:0] hist[$];
  logic [31:0] fr[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] cur_out();
    return big ? {lq1k, rq1k} : {lq8, rq8};
  endfunction

  task automatic model_reset();
    cyc   = 0;
    trig  = -1;
    ovr_e = 1'b0;
    hist.delete();
    fr.delete();
  endtask

  // One clock cycle: check this cycle's outputs, then apply stimulus to the model and DUT.
  task automatic step(input bit v, input logic [15:0] l, input logic [15:0] r);
    bit          in_seq, busy;
    logic [31:0] e;
    @(negedge clk);
    in_seq = trig >= 0 && cyc >= trig + 2 && cyc <= trig + 1 + dep;
    check("sequencing", 32'(big ? seq1k : seq8), 32'(in_seq));
    if (in_seq) begin
      e = fr[cyc - trig - 2];
      check("sample", cur_out(), e);
    end
    check("frame_done", 32'(big ? fd1k : fd8), 32'(trig >= 0 && cyc == trig + 2 + dep));
    check("ovr", 32'(big ? ovr1k : ovr8), 32'(ovr_e));
    if (v) begin
      busy = trig >= 0 && cyc >= trig + 1 && cyc <= trig + 1 + dep;
      if (busy) ovr_e = 1'b1;
      else begin
        hist.push_back({l, r});
        if (hist.size() > dep) void'(hist.pop_front());
        if (ZF || hist.size() >= dep) begin
          trig = cyc;
          fr.delete();
          for (int i = 0; i < dep; i++) begin
            int idx = hist.size() - dep + i;
            fr.push_back(idx >= 0 ? hist[idx] : 32'h0);
          end
        end
      end
    end
    v8   = v & ~big;
    v1k  = v & big;
    lft  = l;
    rght = r;
    @(posedge clk);
    cyc++;
  endtask

  task automatic wait_free();
    while (trig >= 0 && cyc <= trig + 2 + dep) step(1'b0, '0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    v8    = 1'b0;
    v1k   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_seq", 32'(big ? seq1k : seq8), 32'd0);
    check("rst_out", cur_out(), 32'd0);
    check("rst_done", 32'(big ? fd1k : fd8), 32'd0);
    check("rst_ovr", 32'(big ? ovr1k : ovr8), 32'd0);
    @(posedge clk);
    model_reset();
  endtask

  initial begin
    logic [15:0] n16;
    big = 1'b0;
    dep = 8;
    do_reset();
    for (int n = 1; n <= 7; n++) begin
      n16 = 16'(n);
      step(1'b1, n16, -n16);
      step(1'b0, '0, '0);
    end
    step(1'b1, 16'd8, -16'd8);
    wait_free();
    for (int n = 9; n <= 11; n++) begin
      n16 = 16'(n);
      step(1'b1, n16, -n16);
      wait_free();
    end
    // Overrun landing in the fourth streaming cycle.
    step(1'b1, 16'd12, -16'd12);
    repeat (4) step(1'b0, '0, '0);
    step(1'b1, 16'd99, 16'd99);
    wait_free();
    step(1'b1, 16'd13, -16'd13);
    wait_free();
    repeat (400) step($urandom_range(0, 2) == 0, 16'($urandom), 16'($urandom));
    wait_free();

    big = 1'b1;
    dep = 1021;
    do_reset();
    for (int n = 0; n < 1021; n++) step(1'b1, 16'(n), 16'(n * 3));
    wait_free();
    step(1'b1, 16'h1234, 16'h5678);
    repeat (6) step(1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_drop", 32'(seq1k), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    repeat (5) step(1'b1, 16'($urandom), 16'($urandom));
    repeat (12) step(1'b0, '0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
